// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one ibus request at a time,
// buffers one instruction for decode and squashes stale fetches on redirect.
// Optional perf counters are enabled with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        dec_ready,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        stop_forfetch
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_discarded
`endif
);

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            discard, discard_n;
    logic            instr_valid_n;
    logic            take_data;
    logic            stray;
    logic            load;
    logic            drop;
    logic            issue;

    // Next-state, PC and buffer control
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        discard_n     = discard;
        take_data     = 1'b0;
        stray         = 1'b0;
        load          = 1'b0;
        drop          = 1'b0;
        issue         = 1'b0;
        instr_valid_n = instr_valid;

        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (iresp_addr_ok) begin
                    if (iresp_data_ok) take_data = 1'b1;
                    else               state_n   = WAIT;
                end
            end
            WAIT: if (iresp_data_ok) take_data = 1'b1;
            HOLD: if (dec_ready) state_n = REQ;
            default: state_n = IDLE;
        endcase

        // A response with no request of ours in flight is the stale one owed from before
        stray = iresp_data_ok && discard && !take_data;
        if (stray) begin
            discard_n = 1'b0;
            drop      = 1'b1;
        end

        if (take_data) begin
            state_n = REQ;
            if (discard) begin
                drop      = 1'b1;
                discard_n = 1'b0;
            end else if (redirect) begin
                drop = 1'b1;
            end else begin
                load = 1'b1;
                pc_n = pc + XLEN'(PC_STEP);
            end
        end

        // Redirect: retarget the PC; an in-flight request must have its response dropped
        if (redirect) begin
            pc_n = redirect_pc;
            if (!take_data) begin
                if (state == IDLE || state == HOLD) state_n   = REQ;
                else                                discard_n = 1'b1;
            end
        end

        if (redirect)       instr_valid_n = 1'b0;
        else if (load)      instr_valid_n = 1'b1;
        else if (dec_ready) instr_valid_n = 1'b0;

        // New request only when the buffer will be free to take its data
        issue = (state_n == REQ) && !(state == REQ && !iresp_addr_ok);
        if (issue && instr_valid_n) begin
            state_n = HOLD;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            // A fetch still owed by the bus must not be delivered after reset
            discard     <= (state == WAIT) && !iresp_data_ok;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 64'd0;
            ireq_valid  <= 1'b0;
            ireq_addr   <= RESET_PC;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            discard     <= discard_n;
            instr_valid <= instr_valid_n;
            ireq_valid  <= (state_n == REQ);
            if (issue) ireq_addr <= pc_n;
            if (load) begin
                instr    <= iresp_data;
                instr_pc <= pc;
            end
        end
    end

    assign stop_forfetch = ~instr_valid;

`ifdef FETCH_CTRL_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= 64'd0;
            perf_discarded <= 64'd0;
        end else begin
            if (load && !(&perf_fetched))  perf_fetched   <= perf_fetched + 64'd1;
            if (drop && !(&perf_discarded)) perf_discarded <= perf_discarded + 64'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch port.
- Owns the fetch PC, drives the ibus request with one request outstanding at most, and holds the address stable until the bus accepts it.
- Buffers one returned instruction for decode and flushes/discards stale fetches on a branch redirect.
- Sits between the pipeline's PC-select/branch logic and the ibus, replacing ad-hoc valid/bubble generation in the fetch stage.

Parameters:
- RESET_PC, 64'h8000_0000, fetch PC loaded on reset.
- PC_STEP, 4, increment applied after each delivered instruction.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  branch/jump redirect pulse.
- redirect_pc  in  64  new fetch PC, valid with redirect.
- dec_ready  in  1  decode accepts instr this cycle.
- ireq_valid  out  1  ibus request valid.
- ireq_addr  out  64  ibus request address.
- iresp_addr_ok  in  1  ibus accepted address this cycle.
- iresp_data_ok  in  1  ibus returns data this cycle.
- iresp_data  in  32  returned instruction.
- instr_valid  out  1  output buffer holds a valid instruction.
- instr  out  32  buffered instruction.
- instr_pc  out  64  PC of buffered instruction.
- stop_forfetch  out  1  high when instr_valid=0 (fetch bubble to pipeline).

Behaviour:
- Reset (synchronous, dominates all inputs, including mid-transaction):
  - state=IDLE, pc=RESET_PC, discard=0, instr_valid=0.
  - instr=0, instr_pc=0, ireq_valid=0, ireq_addr=RESET_PC, stop_forfetch=1.
  - A response arriving after reset for a pre-reset request is ignored: discard is set if reset occurs in WAIT.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: ireq_valid=0. Next cycle -> REQ.
- REQ:
  - ireq_valid=1, ireq_addr=pc, both held constant until iresp_addr_ok.
  - On addr_ok without data_ok -> WAIT.
  - On addr_ok and data_ok in the same cycle, treat as WAIT's data_ok case.
- WAIT: ireq_valid=0. On data_ok:
  - If discard=1: drop data, discard<=0, -> REQ with current pc.
  - Else if instr_valid=0 or dec_ready=1:
    - instr<=iresp_data, instr_pc<=pc, instr_valid<=1.
    - pc<=pc+PC_STEP (64-bit, wraps modulo 2^64).
    - -> REQ.
  - Else (buffer full, not consumed): cannot occur. Entry to REQ requires the buffer to be free at data return (see HOLD).
- Buffer drain:
  - dec_ready=1 with instr_valid=1 and no new load: instr_valid<=0 next cycle.
  - Load and consume in the same cycle: buffer replaced, instr_valid stays 1.
- HOLD: entered from WAIT/REQ decision when instr_valid=1 and dec_ready=0 at the point a new request would be issued.
  - ireq_valid=0.
  - -> REQ when dec_ready=1.
  - Guarantees at most one outstanding fetch plus one buffered instruction.
- Redirect (highest priority after reset):
  - pc<=redirect_pc; instr_valid<=0 (flush); dec_ready ignored that cycle.
  - In IDLE/HOLD: -> REQ, issuing redirect_pc the next cycle.
  - In REQ without addr_ok: the request stays stable on the old address (bus rule); discard<=1.
  - In REQ with addr_ok (no data_ok): discard<=1, -> WAIT.
  - In WAIT without data_ok: discard<=1.
  - Same cycle as a (non-discarded) data_ok: data dropped, discard stays 0, -> REQ with redirect_pc.
- Redirect while discard=1 already: pc updated again, discard remains 1; only one stale response is dropped.
- stop_forfetch = ~instr_valid (combinational from register).

Optional Feature:
- FETCH_CTRL_PERF_EN defined:
  - Adds outputs perf_fetched (64-bit, +1 per delivered instruction) and perf_discarded (64-bit, +1 per dropped stale response).
  - Both cleared by reset; both saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, addr_ok and data_ok 1 cycle after each request, dec_ready=1 -> ireq_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; instr_pc matches; instr_valid pulses once per fetch.
- Hold addr_ok=0 for 3 cycles -> ireq_valid=1 and ireq_addr=0x8000_0000 constant all 3 cycles; WAIT entered after addr_ok.
- dec_ready=0 after first delivery -> instr_valid stays 1, instr unchanged, ireq_valid=0 (HOLD); dec_ready=1 -> next request 0x8000_0004.
- redirect to 0x8000_1000 in WAIT, then data_ok with 0xDEADBEEF -> data dropped, instr_valid=0, next ireq_addr=0x8000_1000.
- redirect to 0x8000_2000 in the same cycle as addr_ok+data_ok -> no instruction delivered, next ireq_addr=0x8000_2000, discard=0.
- reset asserted in WAIT, stale data_ok next cycle -> ignored; first delivered instr_pc=0x8000_0000.
